// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ST_W = 3;

    // Arbiter FSM states
    localparam logic [ST_W-1:0] IDLE   = 3'd0;
    localparam logic [ST_W-1:0] D_BUSY = 3'd1;
    localparam logic [ST_W-1:0] I_BUSY = 3'd2;
    localparam logic [ST_W-1:0] DONE   = 3'd3;
    localparam logic [ST_W-1:0] ERR    = 3'd4;

    // Which requester owns the current access
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Stall contribution while parked in the error state
    localparam logic ERR_STALL = 1'b1;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating busy-cycle counter; expired_o flags the cycle in which the
// count would reach TIMEOUT (combinational, qualified by en_i).
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up to TIMEOUT and hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port unified memory between IF fetches and MEM
// loads/stores, drives the pipeline stall and traps a hung memory.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRdata,
    output logic              IReady,
    input  logic              DRead,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic [DATA_W-1:0] DRdata,
    output logic              DReady,
    output logic              Stall,
    output logic              Err,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemAck
);

    logic [ST_W-1:0]   state_q,   state_d;
    logic              owner_q,   owner_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q,  mem_we_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q,     err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic busy_c;
    logic expired;

    assign busy_c = (state_q == D_BUSY) || (state_q == I_BUSY);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .clr_i     (~busy_c | MemAck),
        .en_i      (busy_c),
        .expired_o (expired)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = err_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                // Data first: it belongs to the older instruction
                if (DRead || DWrite) begin
                    state_d   = D_BUSY;
                    owner_d   = OWN_D;
                    we_d      = DWrite;
                    addr_d    = DAddr;
                    wdata_d   = DWdata;
                    mem_req_d = 1'b1;
                    mem_we_d  = DWrite;
                end else if (IReq) begin
                    state_d   = I_BUSY;
                    owner_d   = OWN_I;
                    we_d      = 1'b0;
                    addr_d    = IAddr;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                end
            end
            D_BUSY, I_BUSY: begin
                // An acknowledge in the expiry cycle still completes the access
                if (MemAck) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = MemRdata;
                        end
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = MemRdata;
                    end
                end else if (expired) begin
                    state_d   = ERR;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_d     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = addr_q;
    assign MemWdata = wdata_q;
    assign IReady   = i_ready_q;
    assign DReady   = d_ready_q;
    assign IRdata   = i_rdata_q;
    assign DRdata   = d_rdata_q;
    assign Err      = err_q;

    // Pipeline freeze: any requester not yet served, or a trapped memory
    assign Stall = ((DRead | DWrite) & ~DReady)
                 | (IReq & ~IReady)
                 | ((state_q == ERR) ? ERR_STALL : 1'b0);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a scoreboarded memory model.
module tb_unified_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRdata;
    logic        IReady;
    logic        DRead;
    logic        DWrite;
    logic [31:0] DAddr;
    logic [31:0] DWdata;
    logic [31:0] DRdata;
    logic        DReady;
    logic        Stall;
    logic        Err;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemAck;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } mem_op_t;

    mem_op_t     mem_q[$];
    logic [31:0] ir_q[$];
    logic [31:0] dr_q[$];

    int tests;
    int fails;
    int ack_wait;
    int busy_cnt;
    int i_pulses;
    int d_pulses;

    unified_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .IReq     (IReq),
        .IAddr    (IAddr),
        .IRdata   (IRdata),
        .IReady   (IReady),
        .DRead    (DRead),
        .DWrite   (DWrite),
        .DAddr    (DAddr),
        .DWdata   (DWdata),
        .DRdata   (DRdata),
        .DReady   (DReady),
        .Stall    (Stall),
        .Err      (Err),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .MemAck   (MemAck)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: memory model acts at the falling edge, outputs sampled 1ns later
    task automatic step();
        mem_op_t     op;
        logic [31:0] exp;
        @(negedge Clk);
        MemAck = 1'b0;
        if (MemReq) begin
            if (busy_cnt == ack_wait) begin
                MemAck = 1'b1;
                check("mem_access_expected", 32'(mem_q.size() != 0), 32'd1);
                if (mem_q.size() != 0) begin
                    op = mem_q.pop_front();
                    MemRdata = op.rdata;
                    check("mem_addr", MemAddr, op.addr);
                    check("mem_we", 32'(MemWe), 32'(op.we));
                    if (op.we) check("mem_wdata", MemWdata, op.wdata);
                end
            end
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
        #1;
        if (IReady) begin
            i_pulses++;
            check("ipulse_expected", 32'(ir_q.size() != 0), 32'd1);
            if (ir_q.size() != 0) begin
                exp = ir_q.pop_front();
                check("irdata", IRdata, exp);
            end
        end
        if (DReady) begin
            d_pulses++;
            check("dpulse_expected", 32'(dr_q.size() != 0), 32'd1);
            if (dr_q.size() != 0) begin
                exp = dr_q.pop_front();
                check("drdata", DRdata, exp);
            end
        end
    endtask

    // Step until the selected Ready pulses; Stall must hold high meanwhile
    task automatic run_until_ready(input bit is_d, input int max_cyc, input string tag);
        int start;
        bit seen;
        start = is_d ? d_pulses : i_pulses;
        seen  = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            step();
            if ((is_d ? d_pulses : i_pulses) != start) begin
                seen = 1'b1;
            end else begin
                check({tag, "_stall"}, 32'(Stall), 32'd1);
                if (!is_d) check({tag, "_we"}, 32'(MemWe), 32'd0);
            end
        end
        check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    endtask

    function automatic mem_op_t mk(input logic [31:0] a, input logic w,
                                   input logic [31:0] wd, input logic [31:0] rd);
        mem_op_t o;
        o.addr  = a;
        o.we    = w;
        o.wdata = wd;
        o.rdata = rd;
        return o;
    endfunction

    initial begin
        int dp;
        tests = 0; fails = 0; ack_wait = 0; busy_cnt = 0; i_pulses = 0; d_pulses = 0;
        Reset = 1'b1; IReq = 1'b0; IAddr = '0; DRead = 1'b0; DWrite = 1'b0;
        DAddr = '0; DWdata = '0; MemRdata = '0; MemAck = 1'b0;

        // Reset values
        step(); step();
        check("rst_memreq", 32'(MemReq), 32'd0);
        check("rst_memwe", 32'(MemWe), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_memwdata", MemWdata, 32'd0);
        check("rst_irdata", IRdata, 32'd0);
        check("rst_drdata", DRdata, 32'd0);
        check("rst_readys", 32'({IReady, DReady}), 32'd0);
        Reset = 1'b0;
        step();

        // Fetch with two wait cycles
        ack_wait = 2;
        mem_q.push_back(mk(32'h0000_0004, 1'b0, 32'd0, 32'h8C01_0000));
        ir_q.push_back(32'h8C01_0000);
        IReq = 1'b1; IAddr = 32'h0000_0004;
        run_until_ready(1'b0, 20, "fetch");
        check("fetch_stall_at_ready", 32'(Stall), 32'd0);
        IReq = 1'b0;
        step();
        check("fetch_single_pulse", 32'(IReady), 32'd0);

        // Simultaneous I and D requests, zero-wait memory
        ack_wait = 0;
        mem_q.push_back(mk(32'h40, 1'b0, 32'd0, 32'h1111_2222));
        mem_q.push_back(mk(32'h10, 1'b0, 32'd0, 32'h3333_4444));
        dr_q.push_back(32'h1111_2222);
        ir_q.push_back(32'h3333_4444);
        IReq = 1'b1; IAddr = 32'h10; DRead = 1'b1; DAddr = 32'h40;
        step();
        check("sim_dbusy_req", 32'(MemReq), 32'd1);
        check("sim_dbusy_stall", 32'(Stall), 32'd1);
        step();
        check("sim_dready", 32'(DReady), 32'd1);
        check("sim_ddone_stall", 32'(Stall), 32'd1);
        DRead = 1'b0;
        step();
        check("sim_idle_req", 32'(MemReq), 32'd0);
        check("sim_idle_stall", 32'(Stall), 32'd1);
        step();
        check("sim_ibusy_stall", 32'(Stall), 32'd1);
        check("sim_ibusy_ready", 32'(IReady), 32'd0);
        step();
        check("sim_iready", 32'(IReady), 32'd1);
        check("sim_idone_stall", 32'(Stall), 32'd0);
        IReq = 1'b0;
        step();

        // Store: DRdata must keep the previous load value
        ack_wait = 1;
        mem_q.push_back(mk(32'h20, 1'b1, 32'h0000_00AA, 32'hDEAD_BEEF));
        dr_q.push_back(32'h1111_2222);
        DWrite = 1'b1; DAddr = 32'h20; DWdata = 32'h0000_00AA;
        run_until_ready(1'b1, 20, "store");
        DWrite = 1'b0;
        step();
        check("store_single_pulse", 32'(DReady), 32'd0);

        // Read and write together is a store
        ack_wait = 0;
        mem_q.push_back(mk(32'h24, 1'b1, 32'h0000_0055, 32'hCAFE_F00D));
        dr_q.push_back(32'h1111_2222);
        DRead = 1'b1; DWrite = 1'b1; DAddr = 32'h24; DWdata = 32'h0000_0055;
        run_until_ready(1'b1, 20, "rw");
        DRead = 1'b0; DWrite = 1'b0;
        step();

        // Back-to-back loads
        dp = d_pulses;
        mem_q.push_back(mk(32'h100, 1'b0, 32'd0, 32'h0000_00A1));
        dr_q.push_back(32'h0000_00A1);
        DRead = 1'b1; DAddr = 32'h100;
        run_until_ready(1'b1, 20, "b2b_first");
        mem_q.push_back(mk(32'h104, 1'b0, 32'd0, 32'h0000_00A2));
        dr_q.push_back(32'h0000_00A2);
        DAddr = 32'h104;
        run_until_ready(1'b1, 20, "b2b_second");
        DRead = 1'b0;
        step(); step(); step();
        check("b2b_pulse_count", 32'(d_pulses - dp), 32'd2);
        check("b2b_mem_drained", 32'(mem_q.size()), 32'd0);

        // Acknowledge on the last allowed busy cycle beats the watchdog
        ack_wait = 3;
        mem_q.push_back(mk(32'h300, 1'b0, 32'd0, 32'h0000_7777));
        dr_q.push_back(32'h0000_7777);
        DRead = 1'b1; DAddr = 32'h300;
        run_until_ready(1'b1, 20, "late_ack");
        check("late_ack_err", 32'(Err), 32'd0);
        DRead = 1'b0;
        step();

        // Reset in the second I_BUSY cycle aborts the fetch
        ack_wait = 99;
        dp = i_pulses;
        IReq = 1'b1; IAddr = 32'h400;
        step();
        step();
        check("rma_busy_req", 32'(MemReq), 32'd1);
        Reset = 1'b1; IReq = 1'b0;
        step();
        check("rma_memreq", 32'(MemReq), 32'd0);
        check("rma_memaddr", MemAddr, 32'd0);
        check("rma_irdata", IRdata, 32'd0);
        check("rma_drdata", DRdata, 32'd0);
        check("rma_err_stall", 32'({Err, Stall}), 32'd0);
        Reset = 1'b0;
        step(); step(); step();
        check("rma_no_retry", 32'(MemReq), 32'd0);
        check("rma_no_ipulse", 32'(i_pulses - dp), 32'd0);

        // Timeout with TIMEOUT=4 and no acknowledge
        dp = d_pulses;
        DRead = 1'b1; DAddr = 32'h200;
        step(); step(); step(); step();
        check("to_busy4_req", 32'(MemReq), 32'd1);
        check("to_busy4_err", 32'(Err), 32'd0);
        step();
        check("to_err", 32'(Err), 32'd1);
        check("to_memreq", 32'(MemReq), 32'd0);
        check("to_stall", 32'(Stall), 32'd1);
        DRead = 1'b0;
        step(); step(); step();
        check("to_sticky_err", 32'(Err), 32'd1);
        check("to_sticky_stall", 32'(Stall), 32'd1);
        check("to_no_dpulse", 32'(d_pulses - dp), 32'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("to_reset_err", 32'(Err), 32'd0);
        check("to_reset_stall", 32'(Stall), 32'd0);
        step();
        check("to_reset_memreq", 32'(MemReq), 32'd0);

        check("final_mem_drained", 32'(mem_q.size()), 32'd0);
        check("final_ready_drained", 32'(ir_q.size() + dr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the IF-stage fetch and the MEM-stage load/store of the 5-stage pipeline.
- Grants access to one requester at a time, sequences each handshake with the memory, and drives a global Stall that freezes PC, IFID, IDEX and EXMEM while any access is outstanding.
- A watchdog detects a memory that never acknowledges; the block then enters a sticky error state.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum busy cycles without MemAck before the block enters the error state; must be at least 1.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; held until IReady.
- IAddr  in  ADDR_W  fetch address (PC).
- IRdata  out  DATA_W  fetched instruction; valid when IReady=1.
- IReady  out  1  one-cycle fetch-complete pulse.
- DRead  in  1  load request; held until DReady.
- DWrite  in  1  store request; held until DReady.
- DAddr  in  ADDR_W  data address (ALU result).
- DWdata  in  DATA_W  store data.
- DRdata  out  DATA_W  load data; valid when DReady=1.
- DReady  out  1  one-cycle data-complete pulse.
- Stall  out  1  pipeline freeze.
- Err  out  1  sticky timeout flag.
- MemReq  out  1  memory request, held until acknowledged.
- MemWe  out  1  write enable, qualified by MemReq.
- MemAddr  out  ADDR_W  memory address.
- MemWdata  out  DATA_W  memory write data.
- MemRdata  in  DATA_W  memory read data; valid with MemAck.
- MemAck  in  1  memory acknowledge; sampled only while MemReq=1.

Behaviour:
- States: IDLE, D_BUSY, I_BUSY, DONE, ERR.
- Reset values: state IDLE; MemReq, MemWe, IReady, DReady and Err = 0; MemAddr, MemWdata, IRdata and DRdata = 0; watchdog counter = 0.
- IDLE arbitration, evaluated on the edge:
  - DRead or DWrite set: latch DAddr, DWdata and op, then go to D_BUSY.
  - Else IReq set: latch IAddr, then go to I_BUSY.
  - Else stay in IDLE.
  - Data has fixed priority because it belongs to the older instruction.
- D_BUSY / I_BUSY:
  - MemReq=1, with MemAddr and MemWdata driven from the latched registers.
  - MemWe=1 only for a store.
  - The watchdog increments each cycle.
- Acknowledge: on the edge where MemAck=1, capture MemRdata (loads and fetches only), clear the watchdog and go to DONE.
- DONE: lasts exactly one cycle with MemReq=0.
  - IReady=1 or DReady=1 for the serviced requester.
  - The captured data is presented on IRdata or DRdata.
  - The pipeline advances at the end of this cycle, and the next state is IDLE.
- Latency with a zero-wait memory (MemAck=1 in the first busy cycle): request at edge N, ack sampled at N+1, Ready high during cycle N+1..N+2, for 2 cycles total.
- Stall is combinational: (DRead|DWrite)&~DReady | IReq&~IReady | (state==ERR).
  - When I and D requests are simultaneous, Stall stays high through the data access, IDLE and the fetch until IReady.
- DRead and DWrite both high: treated as a store; DRdata is not updated.
- A store never updates DRdata. IRdata and DRdata hold their last captured value between pulses.
- MemAck outside a busy state is ignored.
- Timeout: the watchdog reaching TIMEOUT in a busy state with MemAck=0 causes a transition to ERR.
  - MemAck=1 in that same cycle wins: go to DONE, no error.
  - ERR: MemReq=0, Err=1, Stall=1, no Ready pulses. It is exited only by Reset.
- Reset mid-access: next cycle is IDLE with MemReq=0. No Ready pulse is produced and the aborted access is not retried.
- The watchdog counter width is clog2(TIMEOUT+1) and it saturates at TIMEOUT.

Decomposition:
- Shared package `mem_arb_pkg` holds:
  - the state enum: IDLE, D_BUSY, I_BUSY, DONE, ERR;
  - the owner encoding: OWN_I, OWN_D;
  - the localparam `ERR_STALL`.
- One natural sub-module is `mem_watchdog`, a clear/enable saturating counter with a `expired` output. The FSM stays in the top module.

Test Plan:
- Fetch only: IReq=1, IAddr=0x0000_0004, MemAck two cycles after MemReq rises, MemRdata=0x8C01_0000 -> IReady pulses one cycle with IRdata=0x8C01_0000; Stall high until that cycle; MemWe=0 throughout.
- Simultaneous requests:
  - Stimulus: IReq with IAddr=0x10, DRead with DAddr=0x40 in the same cycle, zero-wait memory.
  - Required: first MemAddr=0x40 and DReady; then one IDLE cycle; then MemAddr=0x10 and IReady; Stall continuous until IReady.
- Store: DWrite=1, DAddr=0x20, DWdata=0x0000_00AA -> MemWe=1, MemWdata=0xAA while MemReq; DReady pulses; DRdata unchanged from its prior value.
- Timeout, TIMEOUT=4:
  - Stimulus: DRead with MemAck held at 0.
  - Required: after 4 busy cycles the block is in ERR with Err=1, Stall=1 and MemReq=0; it stays there until Reset, which returns Err=0 and IDLE.
  - Variant: MemAck=1 on the 4th busy cycle gives DONE with no error.
- Reset mid-access: Reset in the 2nd cycle of I_BUSY -> next cycle MemReq=0, IReady never pulses, all outputs at their reset values.
- Back-to-back loads: two DRead accesses with a changed DAddr after the first DReady -> two distinct memory accesses, each producing exactly one DReady pulse, with no duplicate service of the first request.
